spi_packet_rx: RTL and testbench
================================

Name: spi_packet_rx

Overview:
SPI slave receiver on the waveform-generator board, directly downstream of the control board's 18-bit SPI master. Oversamples sclk/mosi/cs_n in the local clk domain and deserialises each 18-bit frame, MSB first, as {divider[15:0], wave_sel[1:0]}. Validated fields are committed to held output registers with a one-cycle update strobe for the waveform/tone generator. Malformed frames are rejected with an error strobe.

Parameters:
PACKET_BITS, 18, frame length in bits; must equal DIV_BITS+2
DIV_BITS, 16, divider field width
SYNC_STAGES, 2, synchroniser flops per SPI input (>=2)
MIN_DIV, 1, smallest accepted divider; frames with divider < MIN_DIV are rejected
RESET_DIV, 250, divider value after reset

Ports:
clk  in  1  system clock, 12 MHz
rst  in  1  synchronous active-high reset
sclk  in  1  SPI clock from master, async; idles low (mode 0)
mosi  in  1  SPI data from master, async; sampled on sclk rising
cs_n  in  1  SPI chip select, active low, async
wave_sel  out  2  committed waveform select
divider  out  DIV_BITS  committed frequency divider
update  out  1  one-cycle pulse when wave_sel/divider take new values
frame_err  out  1  one-cycle pulse when a frame is rejected
rx_active  out  1  high while in SHIFT

Behaviour:
- Reset values: wave_sel=2'b00, divider=RESET_DIV, update=0, frame_err=0, rx_active=0. Synchroniser flops reset to sclk=0, mosi=0, cs_n=1. FSM resets to RESYNC. Shift register and bit counter reset to 0.
- Synchronisation:
  - Each input passes through SYNC_STAGES flops. mosi uses the same depth as sclk so data and clock stay aligned.
  - Edges are detected against a one-cycle-delayed copy of the synced signal.
- Input timing: sclk high and low phases must each last >= SYNC_STAGES+1 clk cycles. Master setup holds mosi stable across the sclk rising edge.
- FSM states:
  - RESYNC: wait for synced cs_n==1, then go to IDLE. Ignores all sclk edges. Prevents a frame already in progress at reset from being captured.
  - IDLE: on synced cs_n falling edge, clear shift register and bit counter, go to SHIFT.
  - SHIFT: on each synced sclk rising edge, shift_reg <= {shift_reg[PACKET_BITS-2:0], mosi_sync}. Bit counter increments, saturating at PACKET_BITS+1. On synced cs_n rising edge, evaluate the frame and go to IDLE.
- Evaluation at cs_n rising edge:
  - Accept only if count==PACKET_BITS and shift_reg[PACKET_BITS-1:2] >= MIN_DIV.
  - On accept, next cycle: divider <= shift_reg[PACKET_BITS-1:2], wave_sel <= shift_reg[1:0], update=1 for exactly one cycle.
  - Otherwise: frame_err=1 for one cycle; outputs hold their prior values.
  - update and frame_err are never high together.
- Latency: let edge N be the clk edge that first samples pin cs_n high. New outputs and update are visible after edge N+SYNC_STAGES+1.
- Simultaneous events: an sclk rising edge detected in the same cycle as the cs_n rising edge is discarded (cs_n has priority). A cs_n falling edge in the update cycle starts a new frame normally, so back-to-back frames are supported.
- Oversized frames: count saturates, so >PACKET_BITS bits is always rejected. The shift register keeps only the last PACKET_BITS bits, but those bits are never committed.
- sclk edges while cs_n is high are ignored.
- rx_active = (state==SHIFT).
- rst mid-frame: all outputs return to reset values immediately on the next edge. FSM goes to RESYNC, and the partial frame is lost even if cs_n stays low.

Test Plan:
- Reset: assert rst 2 cycles, SPI idle -> wave_sel=00, divider=250, update=0, frame_err=0, rx_active=0.
- Valid frame: send {16'd250, 2'b01} with sclk period 8 clk -> exactly one update pulse, divider=250, wave_sel=01, at N+3 cycles; frame_err stays 0.
- Length errors: a 17-bit frame then a 19-bit frame, after an accepted {16'd1000, 2'b10} -> two frame_err pulses, no update, outputs stay 1000/10.
- Divider below minimum: send {16'd0, 2'b11} -> frame_err pulse, outputs unchanged.
- Back-to-back: {16'd500, 2'b00} then {16'd42, 2'b11}, with cs_n high 4 cycles between -> two update pulses, final 42/11.
- Reset mid-frame: rst after 9 bits with cs_n held low, then 9 more bits, cs_n high -> no update and no frame_err; the next full frame is accepted.

Source files
------------

// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave that deserialises {divider, wave_sel} frames into held
// output registers, with a one-cycle update strobe or frame_err strobe per frame.
module spi_packet_rx #(
    parameter int PACKET_BITS = 18,
    parameter int DIV_BITS    = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_DIV     = 1,
    parameter int RESET_DIV   = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                mosi,
    input  logic                cs_n,
    output logic [1:0]          wave_sel,
    output logic [DIV_BITS-1:0] divider,
    output logic                update,
    output logic                frame_err,
    output logic                rx_active
);

    localparam int CNT_W = $clog2(PACKET_BITS + 2);
    localparam int RS_W  = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]    CNT_FULL  = CNT_W'(PACKET_BITS);
    localparam logic [CNT_W-1:0]    CNT_SAT   = CNT_W'(PACKET_BITS + 1);
    localparam logic [RS_W-1:0]     RS_DONE   = RS_W'(SYNC_STAGES);
    localparam logic [DIV_BITS-1:0] MIN_DIV_V = DIV_BITS'(MIN_DIV);
    localparam logic [DIV_BITS-1:0] RST_DIV_V = DIV_BITS'(RESET_DIV);

    typedef enum logic [1:0] {
        S_RESYNC = 2'd0,
        S_IDLE   = 2'd1,
        S_SHIFT  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;

    state_t                 r_state;
    logic [PACKET_BITS-1:0] r_shift;
    logic [CNT_W-1:0]       r_cnt;
    logic [RS_W-1:0]        r_rs_cnt;
    logic                   r_pend_ok;
    logic                   r_pend_err;
    logic [1:0]             r_wave;
    logic [DIV_BITS-1:0]    r_div;
    logic                   r_update;
    logic                   r_frame_err;

    logic                   w_sclk_s;
    logic                   w_mosi_s;
    logic                   w_cs_s;
    logic                   w_sclk_rise;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic [DIV_BITS-1:0]    w_field_div;
    logic                   w_accept;

    // mosi shares the sclk depth so the sampled bit lines up with the detected edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;
    assign w_field_div = r_shift[PACKET_BITS-1:2];
    assign w_accept    = (r_cnt == CNT_FULL) && (w_field_div >= MIN_DIV_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RESYNC;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_rs_cnt    <= '0;
            r_pend_ok   <= 1'b0;
            r_pend_err  <= 1'b0;
            r_wave      <= 2'b00;
            r_div       <= RST_DIV_V;
            r_update    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_pend_ok   <= 1'b0;
            r_pend_err  <= 1'b0;
            r_update    <= r_pend_ok;
            r_frame_err <= r_pend_err;
            // shift register is frozen between evaluation and commit
            if (r_pend_ok) begin
                r_div  <= w_field_div;
                r_wave <= r_shift[1:0];
            end
            case (r_state)
                S_RESYNC: begin
                    // cs_n must stay high long enough to flush the reset value out of the synchroniser
                    if (w_cs_s) begin
                        if (r_rs_cnt == RS_DONE) begin
                            r_state  <= S_IDLE;
                            r_rs_cnt <= '0;
                        end else begin
                            r_rs_cnt <= r_rs_cnt + 1'b1;
                        end
                    end else begin
                        r_rs_cnt <= '0;
                    end
                end
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_cs_rise) begin
                        r_state    <= S_IDLE;
                        r_pend_ok  <= w_accept;
                        r_pend_err <= ~w_accept;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[PACKET_BITS-2:0], w_mosi_s};
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= S_RESYNC;
            endcase
        end
    end

    assign wave_sel  = r_wave;
    assign divider   = r_div;
    assign update    = r_update;
    assign frame_err = r_frame_err;
    assign rx_active = (r_state == S_SHIFT);

endmodule

// File: tb/tb_spi_packet_rx.sv
// Randomised frame-level bench for spi_packet_rx: each frame's outcome is
// predicted from its length and divider field, then checked at fixed latency.
module tb_spi_packet_rx;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic        cs_n;
    logic [1:0]  wave_sel;
    logic [15:0] divider;
    logic        update;
    logic        frame_err;
    logic        rx_active;

    int n_cmp = 0;
    int n_err = 0;
    int upd_cycles = 0;
    int err_cycles = 0;
    int both_cycles = 0;
    int exp_upd = 0;
    int exp_err = 0;
    int frame_no = 0;
    logic [15:0] exp_div;
    logic [1:0]  exp_wave;

    spi_packet_rx dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .wave_sel  (wave_sel),
        .divider   (divider),
        .update    (update),
        .frame_err (frame_err),
        .rx_active (rx_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (update) upd_cycles++;
            if (frame_err) err_cycles++;
            if (update && frame_err) both_cycles++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outcome: 0 = nothing, 1 = accepted, 2 = rejected
    function automatic int predict(input logic [31:0] data, input int nbits);
        int div_field;
        div_field = int'((data >> 2) & 32'hFFFF);
        if (nbits == 18 && div_field >= 1) return 1;
        return 2;
    endfunction

    task automatic send_bits(input logic [31:0] data, input int hi, input int lo, input int half);
        for (int i = hi; i >= lo; i--) begin
            mosi = data[i];
            repeat (half) @(posedge clk);
            #1 sclk = 1'b1;
            repeat (half) @(posedge clk);
            #1 sclk = 1'b0;
        end
    endtask

    task automatic end_frame(input int kind, input int gap, input logic [31:0] data, input int nbits);
        @(posedge clk);
        #1 cs_n = 1'b1;
        if (kind == 1) begin
            exp_div  = data[17:2];
            exp_wave = data[1:0];
            exp_upd++;
        end else if (kind == 2) begin
            exp_err++;
        end
        repeat (3) begin
            @(posedge clk);
            #1 chk("pulse_early", {30'd0, update, frame_err}, 32'd0);
        end
        @(posedge clk);
        #1;
        chk("update", {31'd0, update}, {31'd0, kind == 1});
        chk("frame_err", {31'd0, frame_err}, {31'd0, kind == 2});
        chk("divider", {16'd0, divider}, {16'd0, exp_div});
        chk("wave_sel", {30'd0, wave_sel}, {30'd0, exp_wave});
        $display("frame %0d: bits=%0d data=%05h kind=%0d -> div=%0d wave=%0d upd=%0b err=%0b",
                 frame_no, nbits, data, kind, divider, wave_sel, update, frame_err);
        frame_no++;
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_frame(input logic [31:0] data, input int nbits, input int half, input int gap);
        @(posedge clk);
        #1 cs_n = 1'b0;
        send_bits(data, nbits - 1, 0, half);
        chk("rx_active", {31'd0, rx_active}, 32'd1);
        end_frame(predict(data, nbits), gap, data, nbits);
    endtask

    initial begin
        logic [31:0] d;
        int nb;
        int sel;
        rst  = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        exp_div  = 16'd250;
        exp_wave = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_wave", {30'd0, wave_sel}, 32'd0);
        chk("rst_div", {16'd0, divider}, 32'd250);
        chk("rst_update", {31'd0, update}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_active", {31'd0, rx_active}, 32'd0);
        repeat (6) @(posedge clk);

        do_frame({14'd0, 16'd250, 2'b01}, 18, 4, 4);
        do_frame({14'd0, 16'd1000, 2'b10}, 18, 4, 4);
        do_frame({15'd0, 17'h1A5A5}, 17, 4, 4);
        do_frame({13'd0, 19'h5A5A5}, 19, 4, 4);
        do_frame({14'd0, 16'd0, 2'b11}, 18, 4, 4);
        do_frame({14'd0, 16'd1, 2'b10}, 18, 3, 4);
        do_frame({14'd0, 16'd500, 2'b00}, 18, 4, 0);
        do_frame({14'd0, 16'd42, 2'b11}, 18, 4, 4);

        // reset in the middle of a frame with cs_n held low
        d = {14'd0, 16'd777, 2'b01};
        @(posedge clk);
        #1 cs_n = 1'b0;
        send_bits(d, 17, 9, 4);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_div  = 16'd250;
        exp_wave = 2'b00;
        chk("midrst_div", {16'd0, divider}, 32'd250);
        chk("midrst_wave", {30'd0, wave_sel}, 32'd0);
        chk("midrst_active", {31'd0, rx_active}, 32'd0);
        send_bits(d, 8, 0, 4);
        chk("resync_active", {31'd0, rx_active}, 32'd0);
        end_frame(0, 4, d, 9);
        do_frame({14'd0, 16'd1234, 2'b10}, 18, 4, 4);

        for (int k = 0; k < 20; k++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: nb = 16;
                1: nb = 17;
                2: nb = 19;
                3: nb = 20;
                default: nb = 18;
            endcase
            d = $urandom;
            if (nb == 18) begin
                sel = int'($urandom_range(0, 5));
                if (sel == 0) d[17:2] = 16'd0;
                else if (sel == 1) d[17:2] = 16'd1;
                else if (sel == 2) d[17:2] = 16'hFFFF;
            end
            d = d & ((32'd1 << nb) - 32'd1);
            do_frame(d, nb, int'($urandom_range(3, 6)), int'($urandom_range(0, 4)));
        end

        repeat (4) @(posedge clk);
        chk("update_cycles", upd_cycles, exp_upd);
        chk("ferr_cycles", err_cycles, exp_err);
        chk("both_high", both_cycles, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
